// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life engine.
// Holds the FSM state enum, the B3/S23 rule constants and neighbour offset helpers.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_e;

    localparam logic [3:0] BIRTH_N    = 4'd3;
    localparam logic [3:0] SURVIVE_LO = 4'd2;
    localparam logic [3:0] SURVIVE_HI = 4'd3;

    // Neighbour k = 0..7 scans NW, N, NE, W, E, SW, S, SE.
    function automatic int nb_dr(input int k);
        if (k < 3) begin
            return -1;
        end else if (k < 5) begin
            return 0;
        end
        return 1;
    endfunction

    function automatic int nb_dc(input int k);
        case (k)
            0, 3, 5: return -1;
            1, 6:    return 0;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/life_cell.sv
// Single-cell B3/S23 update: counts eight neighbour bits and decides the next state.
module life_cell
    import life_pkg::*;
(
    input  logic       centre_i,
    input  logic [7:0] nbrs_i,
    output logic       next_o
);

    logic [3:0] count;

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, nbrs_i[i]};
        end
        next_o = (count == BIRTH_N) ||
                 (centre_i && (count >= SURVIVE_LO) && (count <= SURVIVE_HI));
    end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life engine: registered grid, generation counter, status flags and an
// IDLE/RUN/HALT controller; the next generation is computed combinationally.
module life_engine
    import life_pkg::*;
#(
    parameter int          ROWS  = 8,
    parameter int          COLS  = 8,
    parameter int unsigned WRAP  = 0,
    parameter int unsigned GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 run,
    input  logic                 step,
    input  logic [GEN_W-1:0]     max_gen,
    output logic [ROWS*COLS-1:0] grid,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 busy,
    output logic                 stable,
    output logic                 extinct,
    output logic                 done
);

    localparam int N = ROWS * COLS;

    state_e           state_q, state_d;
    logic [N-1:0]     grid_q, grid_d, next_grid;
    logic [GEN_W-1:0] gen_q, gen_d, gen_inc;
    logic             stable_q, stable_d;
    logic             done_q, done_d;
    logic             commit;
    logic             halt_cond;

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            localparam int CBIT = (ROWS - 1 - gr) * COLS + (COLS - 1 - gc);
            logic [7:0] nb;

            for (genvar k = 0; k < 8; k++) begin : g_nb
                localparam int NR = gr + nb_dr(k);
                localparam int NC = gc + nb_dc(k);
                localparam int WR = (NR + ROWS) % ROWS;
                localparam int WC = (NC + COLS) % COLS;
                localparam bit INSIDE = (NR >= 0) && (NR < ROWS) && (NC >= 0) && (NC < COLS);
                localparam int NBIT = (ROWS - 1 - WR) * COLS + (COLS - 1 - WC);
                if (WRAP != 0 || INSIDE) begin : g_live
                    assign nb[k] = grid_q[NBIT];
                end else begin : g_dead
                    assign nb[k] = 1'b0;
                end
            end

            life_cell u_cell (
                .centre_i (grid_q[CBIT]),
                .nbrs_i   (nb),
                .next_o   (next_grid[CBIT])
            );
        end
    end

    always_comb begin
        gen_inc   = gen_q + GEN_W'(1);
        halt_cond = (next_grid == grid_q) || (next_grid == '0) ||
                    ((max_gen != '0) && (gen_inc == max_gen)) || (gen_inc == '1);

        state_d  = state_q;
        grid_d   = grid_q;
        gen_d    = gen_q;
        stable_d = stable_q;
        commit   = 1'b0;

        if (load) begin
            grid_d   = seed;
            gen_d    = '0;
            stable_d = 1'b0;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = RUN;
                    end else if (step) begin
                        commit = 1'b1;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_d = IDLE;
                    end else begin
                        commit = 1'b1;
                        if (halt_cond) begin
                            state_d = HALT;
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (commit) begin
                grid_d   = next_grid;
                gen_d    = gen_inc;
                stable_d = (next_grid == grid_q);
            end
        end

        done_d = (state_d == HALT) && (state_q != HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grid_q   <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            gen_q    <= gen_d;
            stable_q <= stable_d;
            done_q   <= done_d;
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign busy      = (state_q == RUN);
    assign stable    = stable_q;
    assign extinct   = (grid_q == '0);
    assign done      = done_q;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: a bounded 8x8 instance and a toroidal 8x8 instance
// share one stimulus set; each scenario task checks its own expected values.
module tb_life_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [63:0] seed = '0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [15:0] max_gen = '0;

    logic [63:0] grid, w_grid;
    logic [15:0] gen_count, w_gen_count;
    logic        busy, stable, extinct, done;
    logic        w_busy, w_stable, w_extinct, w_done;

    int checks = 0;
    int errors = 0;

    // Row 0 is the most significant byte; column 0 is bit 7 of each byte.
    localparam logic [63:0] BLINK_H = 64'h0000_0038_0000_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_1010_1000_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] GLIDER  = 64'h4020_E000_0000_0000;
    localparam logic [63:0] SINGLE  = 64'h0000_0010_0000_0000;
    localparam logic [63:0] MIXED   = 64'h0412_6424_0034_3C28;

    life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .run       (run),
        .step      (step),
        .max_gen   (max_gen),
        .grid      (grid),
        .gen_count (gen_count),
        .busy      (busy),
        .stable    (stable),
        .extinct   (extinct),
        .done      (done)
    );

    life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16)) u_dut_wrap (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .run       (run),
        .step      (step),
        .max_gen   (max_gen),
        .grid      (w_grid),
        .gen_count (w_gen_count),
        .busy      (w_busy),
        .stable    (w_stable),
        .extinct   (w_extinct),
        .done      (w_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] pattern);
        seed = pattern;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (grid !== 64'h0 || gen_count !== 16'h0 || busy !== 1'b0 || stable !== 1'b0 ||
            extinct !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grid=%h gen=%0d busy=%b stable=%b extinct=%b done=%b, want 0/0/0/0/1/0",
                     grid, gen_count, busy, stable, extinct, done);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (grid !== 64'h0 || gen_count !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: grid=%h gen=%0d busy=%b, want 0/0/0", grid, gen_count, busy);
        end
    endtask

    task automatic test_step_blinker();
        do_load(BLINK_H);
        checks++;
        if (grid !== BLINK_H || gen_count !== 16'd0 || extinct !== 1'b0) begin
            errors++;
            $display("FAIL blinker_load: grid=%h gen=%0d extinct=%b, want %h/0/0",
                     grid, gen_count, extinct, BLINK_H);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if (grid !== BLINK_V || gen_count !== 16'd1 || busy !== 1'b0 || stable !== 1'b0) begin
            errors++;
            $display("FAIL blinker_step1: grid=%h gen=%0d busy=%b stable=%b, want %h/1/0/0",
                     grid, gen_count, busy, stable, BLINK_V);
        end
        tick();
        checks++;
        if (grid !== BLINK_V || gen_count !== 16'd1) begin
            errors++;
            $display("FAIL blinker_idle_hold: grid=%h gen=%0d, want %h/1", grid, gen_count, BLINK_V);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if (grid !== BLINK_H || gen_count !== 16'd2 || stable !== 1'b0) begin
            errors++;
            $display("FAIL blinker_step2: grid=%h gen=%0d stable=%b, want %h/2/0",
                     grid, gen_count, stable, BLINK_H);
        end
    endtask

    task automatic test_block_still();
        do_load(BLOCK);
        run = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || gen_count !== 16'd0) begin
            errors++;
            $display("FAIL block_enter_run: busy=%b gen=%0d, want 1/0", busy, gen_count);
        end
        tick();
        checks++;
        if (grid !== BLOCK || gen_count !== 16'd1 || stable !== 1'b1 || done !== 1'b1 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL block_halt: grid=%h gen=%0d stable=%b done=%b busy=%b, want %h/1/1/1/0",
                     grid, gen_count, stable, done, busy, BLOCK);
        end
        tick();
        checks++;
        if (done !== 1'b0 || gen_count !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL block_done_pulse: done=%b gen=%0d busy=%b, want 0/1/0", done, gen_count, busy);
        end
        run = 1'b0;
    endtask

    task automatic test_glider_wrap();
        max_gen = 16'd0;
        do_load(GLIDER);
        run = 1'b1;
        tick();
        repeat (32) tick();
        checks++;
        if (w_grid !== GLIDER || w_gen_count !== 16'd32 || w_busy !== 1'b1 || w_stable !== 1'b0) begin
            errors++;
            $display("FAIL glider_period32: grid=%h gen=%0d busy=%b stable=%b, want %h/32/1/0",
                     w_grid, w_gen_count, w_busy, w_stable, GLIDER);
        end
        tick();
        checks++;
        if (w_grid === GLIDER || w_gen_count !== 16'd33 || w_busy !== 1'b1) begin
            errors++;
            $display("FAIL glider_continues: grid=%h gen=%0d busy=%b, want grid!=seed/33/1",
                     w_grid, w_gen_count, w_busy);
        end
        run = 1'b0;
        tick();
        checks++;
        if (w_gen_count !== 16'd33 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL glider_run_low: gen=%0d busy=%b, want 33/0", w_gen_count, w_busy);
        end
    endtask

    task automatic test_extinct();
        do_load(SINGLE);
        run = 1'b1;
        tick();
        tick();
        checks++;
        if (grid !== 64'h0 || extinct !== 1'b1 || gen_count !== 16'd1 || done !== 1'b1 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL single_extinct: grid=%h extinct=%b gen=%0d done=%b busy=%b, want 0/1/1/1/0",
                     grid, extinct, gen_count, done, busy);
        end
        run = 1'b0;
    endtask

    task automatic test_max_gen();
        max_gen = 16'd5;
        do_load(MIXED);
        run = 1'b1;
        tick();
        repeat (4) tick();
        checks++;
        if (gen_count !== 16'd4 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL maxgen_before: gen=%0d busy=%b done=%b, want 4/1/0", gen_count, busy, done);
        end
        tick();
        checks++;
        if (gen_count !== 16'd5 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL maxgen_halt: gen=%0d busy=%b done=%b, want 5/0/1", gen_count, busy, done);
        end
        step = 1'b1;
        repeat (2) tick();
        step = 1'b0;
        checks++;
        if (gen_count !== 16'd5 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL halt_frozen: gen=%0d busy=%b done=%b, want 5/0/0", gen_count, busy, done);
        end
    endtask

    task automatic test_load_from_halt();
        // Still in HALT with run high from the previous scenario.
        seed = BLINK_H;
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (grid !== BLINK_H || gen_count !== 16'd0 || busy !== 1'b0 || stable !== 1'b0) begin
            errors++;
            $display("FAIL halt_load: grid=%h gen=%0d busy=%b stable=%b, want %h/0/0/0",
                     grid, gen_count, busy, stable, BLINK_H);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || gen_count !== 16'd0) begin
            errors++;
            $display("FAIL halt_load_run: busy=%b gen=%0d, want 1/0", busy, gen_count);
        end
        tick();
        checks++;
        if (grid !== BLINK_V || gen_count !== 16'd1) begin
            errors++;
            $display("FAIL halt_load_commit: grid=%h gen=%0d, want %h/1", grid, gen_count, BLINK_V);
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        max_gen = 16'd0;
        do_load(GLIDER);
        run = 1'b1;
        tick();
        repeat (3) tick();
        checks++;
        if (w_gen_count !== 16'd3 || w_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_gen3: gen=%0d busy=%b, want 3/1", w_gen_count, w_busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (w_grid !== 64'h0 || w_gen_count !== 16'd0 || w_busy !== 1'b0 || w_stable !== 1'b0 ||
            w_done !== 1'b0 || w_extinct !== 1'b1) begin
            errors++;
            $display("FAIL midrun_async_reset: grid=%h gen=%0d busy=%b stable=%b done=%b extinct=%b",
                     w_grid, w_gen_count, w_busy, w_stable, w_done, w_extinct);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (w_grid !== 64'h0 || w_gen_count !== 16'd0 || w_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_release: grid=%h gen=%0d busy=%b, want 0/0/1",
                     w_grid, w_gen_count, w_busy);
        end
        run = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_step_blinker();
        test_block_still();
        test_glider_wrap();
        test_extinct();
        test_max_gen();
        test_load_from_halt();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 Parameter ROWS, default 8, number of grid rows (>=3).
REQ-002 Parameter COLS, default 8, number of grid columns (>=3).
REQ-003 Parameter WRAP, default 0: 0 = cells beyond the edge are dead; 1 = toroidal neighbourhood.
REQ-004 Parameter GEN_W, default 16, width of the generation counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 load  input  1  capture seed into the grid.
REQ-008 seed  input  ROWS*COLS  initial pattern.
REQ-009 run  input  1  level; free-running evolution while high.
REQ-010 step  input  1  single-generation request (sampled per cycle).
REQ-011 max_gen  input  GEN_W  generation limit; 0 = unlimited.
REQ-012 grid  output  ROWS*COLS  current generation, registered.
REQ-013 gen_count  output  GEN_W  generations computed since last load.
REQ-014 busy  output  1  high in state RUN.
REQ-015 stable  output  1  last committed generation equalled its predecessor.
REQ-016 extinct  output  1  grid is all zero.
REQ-017 done  output  1  one-cycle pulse on entry to HALT.

Function
REQ-018 Cell (r,c) shall map to bit (ROWS-1-r)*COLS + (COLS-1-c); row 0 occupies the most significant COLS bits.
REQ-019 Next state per cell shall follow B3/S23: live with 2 or 3 live neighbours survives, dead with exactly 3 becomes live, else dead.
REQ-020 Neighbour count shall use 8 neighbours, 4-bit sum; edge handling per WRAP.
REQ-021 FSM states shall be IDLE, RUN, HALT.
REQ-022 load shall have top priority in every state: grid<=seed, gen_count<=0, stable<=0, state<=IDLE, one cycle latency.
REQ-023 IDLE: run high (no load) -> RUN; step high (no load, no run) -> one generation committed next edge, remain IDLE.
REQ-024 Each committed generation: grid<=next, gen_count<=gen_count+1, stable<=(next==grid).
REQ-025 RUN: commit one generation per cycle; run low -> IDLE with no commit that cycle.
REQ-026 RUN -> HALT on the commit where next==grid, next==0, gen_count+1==max_gen (max_gen!=0), or gen_count+1 reaches all-ones; that generation is still committed.
REQ-027 HALT: grid and gen_count frozen; run and step ignored; exit only by load or reset.
REQ-028 done shall be high exactly the first cycle in HALT.
REQ-029 extinct shall be combinational (grid==0) from the grid register.
REQ-030 step while in RUN or HALT shall be ignored.

Reset
REQ-031 reset high shall asynchronously force state=IDLE, grid=0, gen_count=0, stable=0, done=0, busy=0; extinct therefore reads 1.
REQ-032 reset mid-RUN shall abandon the generation in flight; no commit on the edge reset is released.

Structure
REQ-033 Package life_pkg shall hold the state enum (IDLE, RUN, HALT) and rule constants BIRTH_N=3, SURVIVE_LO=2, SURVIVE_HI=3.
REQ-034 Sub-module life_cell (centre bit, 8 neighbour bits -> next bit) shall be instantiated ROWS*COLS times via generate.
REQ-035 Grid, counter, flags and FSM shall live in life_engine; next-grid logic purely combinational.

Verification
REQ-036 8x8, WRAP=0, seed blinker rows 3 = 8'b00111000 elsewhere 0, step pulse -> column of three at col 3, rows 2-4; second step restores seed, gen_count=2.
REQ-037 Seed 2x2 block at rows 3-4 cols 3-4, run=1 -> one commit, stable=1, HALT, done pulse, gen_count=1.
REQ-038 8x8, WRAP=1, glider seed, max_gen=0, run=1 -> after 32 generations grid equals seed and evolution continues (not stable).
REQ-039 Single live cell, run=1 -> grid=0, extinct=1, HALT after gen_count=1; seed 64'h0412_6424_0034_3C28, max_gen=5 -> HALT with gen_count=5.
REQ-040 reset asserted mid-RUN at gen 3 -> all outputs at reset values immediately; load and run during HALT -> IDLE with seed, then RUN next cycle.
